broadcast_vec_fetch: RTL and testbench

Vector fetch stage that feeds the broadcast tile generator. On a start command it walks a strided address sequence in the on-chip vector SRAM, absorbs the SRAM's fixed one-cycle read latency, buffers returned words in a small FIFO, and presents them one vector per cycle on a valid/ready interface. It also presents the job's latched broadcast mode, which drives the tile generator's `mode` input directly.

---
 rtl/broadcast_vec_fetch.sv | 152 +++++++++++++++
 tb/tb_broadcast_vec_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/broadcast_vec_fetch.sv
// Strided vector fetch: walks SRAM addresses, absorbs the one-cycle read latency,
// and streams buffered vectors plus the job's broadcast mode to the tile generator.
module broadcast_vec_fetch #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [ADDR_WIDTH-1:0]                       base_addr,
  input  logic [ADDR_WIDTH-1:0]                       stride,
  input  logic [CNT_WIDTH-1:0]                        num_vecs,
  input  logic                                        mode_in,
  output logic                                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                       mem_addr,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]             mem_rd_data,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] vec_out,
  output logic                                        vec_valid,
  input  logic                                        vec_ready,
  output logic                                        vec_last,
  output logic                                        mode_out,
  output logic                                        busy,
  output logic                                        done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    rd_en_q;
  logic                    rd_last_q;
  logic                    pend_q;
  logic                    pend_last_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   stride_q;
  logic [CNT_WIDTH-1:0]    left_q;
  logic                    mode_q;
  logic                    done_q;

  logic [TILE_SIZE*DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]           fifo_last_q;
  logic [PW-1:0]                   wr_ptr_q;
  logic [PW-1:0]                   rd_ptr_q;
  logic [CW-1:0]                   count_q;

  logic          push;
  logic          pop;
  logic [OW-1:0] occ;
  logic          credit_ok;

  // pend_q marks the read whose data is on mem_rd_data this cycle.
  assign push      = pend_q;
  assign pop       = vec_valid & vec_ready;
  // Entries already held or promised, net of this cycle's pop, before granting one more read.
  assign occ       = OW'(count_q) + OW'(pend_q) + OW'(rd_en_q) - OW'(pop);
  assign credit_ok = occ < OW'(FIFO_DEPTH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      addr_q      <= '0;
      stride_q    <= '0;
      left_q      <= '0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      pend_q      <= rd_en_q;
      pend_last_q <= rd_last_q;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode_in;
            stride_q <= stride;
            if (num_vecs == '0) begin
              done_q <= 1'b1;
            end else begin
              rd_en_q   <= 1'b1;
              addr_q    <= base_addr;
              rd_last_q <= (num_vecs == CNT_WIDTH'(1));
              left_q    <= num_vecs - 1'b1;
              state_q   <= (num_vecs == CNT_WIDTH'(1)) ? S_DRAIN : S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (credit_ok) begin
            rd_en_q   <= 1'b1;
            addr_q    <= addr_q + stride_q;
            left_q    <= left_q - 1'b1;
            rd_last_q <= (left_q == CNT_WIDTH'(1));
            if (left_q == CNT_WIDTH'(1)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && vec_last) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: the FIFO storage carries no reset; occupancy is tracked by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_rd_data;
      fifo_last_q[wr_ptr_q] <= pend_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign vec_valid = (count_q != '0);
  assign vec_out   = fifo_data_q[rd_ptr_q];
  assign vec_last  = vec_valid & fifo_last_q[rd_ptr_q];
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign mode_out  = mode_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_broadcast_vec_fetch.sv
// Bench for broadcast_vec_fetch: SRAM model with random contents, directed and random jobs
// checked against expected address/data/timing sequences built from base + k*stride.
module tb_broadcast_vec_fetch;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [9:0]             base_addr;
  logic [9:0]             stride;
  logic [7:0]             num_vecs;
  logic                   mode_in;
  logic                   mem_rd_en;
  logic [9:0]             mem_addr;
  logic [63:0]            mem_rd_data;
  logic signed [3:0][15:0] vec_out;
  logic                   vec_valid;
  logic                   vec_ready;
  logic                   vec_last;
  logic                   mode_out;
  logic                   busy;
  logic                   done;

  broadcast_vec_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .stride(stride),
    .num_vecs(num_vecs), .mode_in(mode_in), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .vec_out(vec_out), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_last(vec_last), .mode_out(mode_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [63:0] sram [1024];

  logic [9:0]  rd_addr_q  [$];
  int          rd_cyc_q   [$];
  logic [63:0] out_data_q [$];
  bit          out_last_q [$];
  int          out_cyc_q  [$];
  int          done_cyc_q [$];
  bit          busy_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data is valid exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= sram[mem_addr];
    else           mem_rd_data <= {$urandom, $urandom};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) begin
        rd_addr_q.push_back(mem_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (vec_valid && vec_ready) begin
        out_data_q.push_back(vec_out);
        out_last_q.push_back(vec_last);
        out_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    out_data_q.delete();
    out_last_q.delete();
    out_cyc_q.delete();
    done_cyc_q.delete();
    busy_seen = 1'b0;
  endtask

  // rmode: 0 = ready always high, 1 = ready low for cycles 0..9, 2 = random ready.
  task automatic run_job(input logic [9:0] base, input logic [9:0] strd, input logic [7:0] num,
                         input logic md, input int rmode, input bit inject);
    int          t0;
    int          rel;
    int          n;
    bit          finished;
    logic [63:0] held;
    logic [9:0]  ea;
    clear_logs();
    vec_ready = (rmode != 1);
    tick();
    t0 = cyc;
    base_addr = base; stride = strd; num_vecs = num; mode_in = md; start = 1'b1;
    finished = 1'b0;
    held = '0;
    for (int i = 0; i < 300 && !finished; i++) begin
      tick();
      rel = cyc - t0;
      start = 1'b0;
      if (inject && rel == 2) begin
        start = 1'b1;
        base_addr = base + 10'h155; stride = strd + 10'd7; num_vecs = num + 8'd3; mode_in = ~md;
      end
      case (rmode)
        0:       vec_ready = 1'b1;
        1:       vec_ready = (rel >= 10);
        default: vec_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (rmode == 1 && rel == 3) begin
        held = vec_out;
        check("stall_head", held, sram[base]);
      end
      if (rmode == 1 && rel > 3 && rel < 10) begin
        check("stall_hold", vec_out, held);
        check("stall_valid", 64'(vec_valid), 64'd1);
      end
      if (rmode == 1 && rel == 10) check("stall_reads", 64'(rd_addr_q.size()), 64'd4);
      if (done_cyc_q.size() != 0) finished = 1'b1;
    end
    start = 1'b0;
    vec_ready = 1'b1;
    n = int'(num);
    check("done_count", 64'(done_cyc_q.size()), 64'd1);
    check("rd_count", 64'(rd_addr_q.size()), 64'(n));
    check("out_count", 64'(out_data_q.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      ea = 10'((int'(base) + k * int'(strd)) % 1024);
      if (k < rd_addr_q.size()) begin
        check("rd_addr", 64'(rd_addr_q[k]), 64'(ea));
        if (rmode == 0) check("rd_cycle", 64'(rd_cyc_q[k] - t0), 64'(k + 1));
      end
      if (k < out_data_q.size()) begin
        check("vec_data", out_data_q[k], sram[ea]);
        check("vec_last", 64'(out_last_q[k]), 64'(k == n - 1));
        if (rmode == 0) check("vec_cycle", 64'(out_cyc_q[k] - t0), 64'(k + 3));
      end
    end
    if (done_cyc_q.size() != 0) begin
      if (n == 0)
        check("done_cycle", 64'(done_cyc_q[0] - t0), 64'd1);
      else if (rmode == 0)
        check("done_cycle", 64'(done_cyc_q[0] - t0), 64'(n + 3));
      else if (out_cyc_q.size() != 0)
        check("done_after_last", 64'(done_cyc_q[0]), 64'(out_cyc_q[out_cyc_q.size() - 1] + 1));
    end
    check("mode_out", 64'(mode_out), 64'(md));
    check("busy_seen", 64'(busy_seen), 64'(n != 0));
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(vec_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; stride = '0; num_vecs = '0;
    mode_in = 1'b0; vec_ready = 1'b1; mem_rd_data = '0;
    for (int a = 0; a < 1024; a++) sram[a] = {$urandom, $urandom};
    busy_seen = 1'b0;
    repeat (3) tick();
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_valid", 64'(vec_valid), 64'd0);
    check("rst_last", 64'(vec_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mode", 64'(mode_out), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_job(10'h010, 10'd1, 8'd4, 1'b1, 0, 1'b0);
    run_job(10'h3FE, 10'd3, 8'd3, 1'b0, 0, 1'b0);
    run_job(10'h020, 10'd1, 8'd8, 1'b1, 1, 1'b0);
    run_job(10'h000, 10'd1, 8'd0, 1'b0, 0, 1'b0);
    run_job(10'h080, 10'd2, 8'd5, 1'b1, 0, 1'b1);

    // Reset in cycle 4 of a six-vector job, then a fresh job must see only its own data.
    clear_logs();
    vec_ready = 1'b1;
    tick();
    base_addr = 10'h100; stride = 10'd2; num_vecs = 8'd6; mode_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", 64'(vec_valid), 64'd1);
    tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("mid_rst_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_valid", 64'(vec_valid), 64'd0);
    check("mid_rst_last", 64'(vec_last), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_mode", 64'(mode_out), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_job(10'h200, 10'd5, 8'd5, 1'b0, 0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      run_job(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
              8'($urandom_range(1, 12)), 1'($urandom_range(0, 1)),
              2 * int'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
